// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
//   Shared constants and the receiver FSM state type for the LED-matrix serial link.
//   Frame layout on the wire (MSB-first): 3-bit ID, then either an address field followed by
//   data bits (write frame) or 8 command bits plus one trailing bit (command frame).
package led_matrix_pkg;

    localparam logic [2:0] LM_ID_WRITE = 3'b101;
    localparam logic [2:0] LM_ID_CMD   = 3'b100;

    localparam int LM_ROWS     = 16;
    localparam int LM_COLS     = 24;
    localparam int LM_NUM_BITS = LM_ROWS * LM_COLS;

    localparam int LM_ID_BITS  = 3;
    // 8 command bits plus one don't-care bit that marks the capture point
    localparam int LM_CMD_BITS = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_ADDR,
        S_DATA,
        S_CMD,
        S_SKIP
    } lm_state_t;

endpackage

// File: rtl/led_matrix_rx_if.sv
// led_matrix_rx_if
//   The three serial lines of the LED-matrix link.
//   master : the board driver (drives cs, write, data)
//   slave  : the receiver (samples cs, write, data)
//   cs    - chip select, active low; a frame is one cs-low interval
//   write - serial strobe; data is taken on its rising edge
//   data  - serial data, MSB-first within each field
interface led_matrix_rx_if;

    logic cs;
    logic write;
    logic data;

    modport master (output cs, output write, output data);
    modport slave  (input cs, input write, input data);

endinterface

// File: rtl/serial_sync_edge.sv
// serial_sync_edge
//   Multi-flop synchroniser for one asynchronous line plus rise/fall detection on the
//   synchronised level.
//   Ports:
//     clk  - sampling clock
//     rst  - synchronous, active-high reset (stages load RST_VAL so the idle level
//            does not produce a false edge after reset)
//     d    - asynchronous input line
//     q    - synchronised level
//     rise - 1-cycle pulse on a 0->1 transition of q
//     fall - 1-cycle pulse on a 1->0 transition of q
module serial_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/led_matrix_rx.sv
// led_matrix_rx
//   Receiving end of the LED-matrix serial link. Oversamples cs/write/data, decodes
//   ID + address + data frames into a working buffer and publishes the whole image on fb
//   when a write frame closes.
//   Optional feature macro: LED_RX_CMD_DECODE_EN (decode ID 100 command frames into
//   last_cmd / cmd_valid; when undefined those frames are skipped and the outputs are 0).
//   Ports:
//     clk          - system clock
//     RST          - synchronous, active-high reset
//     link         - serial link (slave modport: cs, write, data)
//     fb           - last completed image; fb[0] = first data bit at address 0
//     frame_done   - 1-cycle pulse when fb is updated
//     frame_nbits  - data bits of the last completed write frame, saturated at NUM_BITS
//     busy         - synchronised cs is low
//     err_id       - 1-cycle pulse on an unsupported ID
//     err_short    - 1-cycle pulse when cs releases before a field completes
//     err_ovf      - data bit beyond NUM_BITS seen; held until the next frame start
//     last_cmd     - last captured command byte
//     cmd_valid    - 1-cycle pulse on command capture
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cs high, waiting for cs fall
//   ID     | shifting the 3-bit frame ID
//   ADDR   | shifting the nibble address
//   DATA   | writing data bits into the working buffer
//   CMD    | shifting 8 command bits + 1 trailing bit
//   SKIP   | ignoring strobes until cs rises
module led_matrix_rx
    import led_matrix_pkg::*;
#(
    parameter int NUM_BITS    = LM_NUM_BITS,
    parameter int ADDR_BITS   = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                RST,
    led_matrix_rx_if.slave      link,
    output logic [NUM_BITS-1:0] fb,
    output logic                frame_done,
    output logic [8:0]          frame_nbits,
    output logic                busy,
    output logic                err_id,
    output logic                err_short,
    output logic                err_ovf,
    output logic [7:0]          last_cmd,
    output logic                cmd_valid
);

    localparam int FB_AW = $clog2(NUM_BITS);
    localparam int NW    = FB_AW + 1;
    localparam int IDX_W = (((ADDR_BITS + 2) > NW) ? (ADDR_BITS + 2) : NW) + 1;
    localparam int CNT_W = 4;
`ifdef LED_RX_CMD_DECODE_EN
    localparam int SH_W  = (ADDR_BITS > 8) ? ADDR_BITS : 8;
`else
    localparam int SH_W  = ADDR_BITS;
`endif

    logic cs_s, cs_rise, cs_fall;
    logic wr_s, wr_rise, wr_fall;
    logic data_s, data_rise, data_fall;
    logic unused_edges;

    serial_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(RST), .d(link.cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
    serial_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_wr (
        .clk(clk), .rst(RST), .d(link.write), .q(wr_s), .rise(wr_rise), .fall(wr_fall));
    serial_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
        .clk(clk), .rst(RST), .d(link.data), .q(data_s), .rise(data_rise), .fall(data_fall));

    assign unused_edges = ^{wr_s, wr_fall, data_rise, data_fall};

    lm_state_t             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [SH_W-1:0]       sh, sh_nxt, sh_in;
    logic [ADDR_BITS-1:0]  addr, addr_nxt;
    logic [NW-1:0]         n, n_nxt;
    logic [NUM_BITS-1:0]   work, work_nxt, fb_nxt;
    logic [8:0]            nbits_nxt;
    logic                  done_nxt, id_err_nxt, short_nxt, ovf_nxt;
    logic [IDX_W-1:0]      wr_idx;
`ifdef LED_RX_CMD_DECODE_EN
    logic [7:0]            cmd_nxt;
    logic                  cmd_vld_nxt;
`endif

    assign busy   = ~cs_s;
    assign sh_in  = {sh[SH_W-2:0], data_s};
    assign wr_idx = IDX_W'({addr, 2'b00}) + IDX_W'(n);

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sh          <= '0;
            addr        <= '0;
            n           <= '0;
            work        <= '0;
            fb          <= '0;
            frame_nbits <= '0;
            frame_done  <= 1'b0;
            err_id      <= 1'b0;
            err_short   <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef LED_RX_CMD_DECODE_EN
            last_cmd    <= '0;
            cmd_valid   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sh          <= sh_nxt;
            addr        <= addr_nxt;
            n           <= n_nxt;
            work        <= work_nxt;
            fb          <= fb_nxt;
            frame_nbits <= nbits_nxt;
            frame_done  <= done_nxt;
            err_id      <= id_err_nxt;
            err_short   <= short_nxt;
            err_ovf     <= ovf_nxt;
`ifdef LED_RX_CMD_DECODE_EN
            last_cmd    <= cmd_nxt;
            cmd_valid   <= cmd_vld_nxt;
`endif
        end
    end

`ifndef LED_RX_CMD_DECODE_EN
    assign last_cmd  = '0;
    assign cmd_valid = 1'b0;
`endif

    // Field lengths are tracked with a down-counter loaded at field entry; the strobe that
    // finds it at zero completes the field.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sh_nxt     = sh;
        addr_nxt   = addr;
        n_nxt      = n;
        work_nxt   = work;
        fb_nxt     = fb;
        nbits_nxt  = frame_nbits;
        done_nxt   = 1'b0;
        id_err_nxt = 1'b0;
        short_nxt  = 1'b0;
        ovf_nxt    = err_ovf;
`ifdef LED_RX_CMD_DECODE_EN
        cmd_nxt     = last_cmd;
        cmd_vld_nxt = 1'b0;
`endif
        if (cs_fall) begin
            // also covers a cs glitch mid-frame: restart decoding, keep the working buffer
            state_nxt = S_ID;
            cnt_nxt   = CNT_W'(LM_ID_BITS - 1);
            ovf_nxt   = 1'b0;
        end else begin
            if (wr_rise) begin
                case (state)
                    S_ID: begin
                        sh_nxt  = sh_in;
                        cnt_nxt = cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            if (sh_in[2:0] == LM_ID_WRITE) begin
                                state_nxt = S_ADDR;
                                cnt_nxt   = CNT_W'(ADDR_BITS - 1);
                            end else if (sh_in[2:0] == LM_ID_CMD) begin
`ifdef LED_RX_CMD_DECODE_EN
                                state_nxt = S_CMD;
                                cnt_nxt   = CNT_W'(LM_CMD_BITS - 1);
`else
                                state_nxt = S_SKIP;
`endif
                            end else begin
                                id_err_nxt = 1'b1;
                                state_nxt  = S_SKIP;
                            end
                        end
                    end
                    S_ADDR: begin
                        sh_nxt  = sh_in;
                        cnt_nxt = cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            addr_nxt  = sh_in[ADDR_BITS-1:0];
                            n_nxt     = '0;
                            state_nxt = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (wr_idx < IDX_W'(NUM_BITS)) begin
                            work_nxt[wr_idx[FB_AW-1:0]] = data_s;
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                        // saturate well above NUM_BITS so frame_nbits stays correct
                        if (n != '1) begin
                            n_nxt = n + NW'(1);
                        end
                    end
`ifdef LED_RX_CMD_DECODE_EN
                    S_CMD: begin
                        sh_nxt  = sh_in;
                        cnt_nxt = cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            // sh still holds the 8 command bits; this strobe is the trailing bit
                            cmd_nxt     = sh[7:0];
                            cmd_vld_nxt = 1'b1;
                            state_nxt   = S_SKIP;
                        end
                    end
`endif
                    default: ;
                endcase
            end

            // Evaluated on the post-strobe state so a bit arriving with cs_rise is kept.
            if (cs_rise) begin
                case (state_nxt)
                    S_DATA: begin
                        fb_nxt    = work_nxt;
                        done_nxt  = 1'b1;
                        nbits_nxt = (n_nxt >= NW'(NUM_BITS)) ? 9'(NUM_BITS) : 9'(n_nxt);
                    end
                    S_ID, S_ADDR, S_CMD: short_nxt = 1'b1;
                    default: ;
                endcase
                state_nxt = S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_rx.sv
module tb_led_matrix_rx;

    localparam int NB      = 384;
    localparam int K_DONE  = 0;
    localparam int K_ID    = 1;
    localparam int K_SHORT = 2;
    localparam int K_CMD   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_matrix_rx_if link();

    logic [NB-1:0] fb;
    logic          frame_done, busy, err_id, err_short, err_ovf, cmd_valid;
    logic [8:0]    frame_nbits;
    logic [7:0]    last_cmd;

    led_matrix_rx dut (
        .clk(clk), .RST(rst), .link(link), .fb(fb), .frame_done(frame_done),
        .frame_nbits(frame_nbits), .busy(busy), .err_id(err_id), .err_short(err_short),
        .err_ovf(err_ovf), .last_cmd(last_cmd), .cmd_valid(cmd_valid)
    );

    typedef struct {
        int            kind;
        logic [NB-1:0] fb;
        int            nbits;
        bit            ovf;
        int            cmd;
    } exp_t;

    exp_t          expq[$];
    int            total = 0;
    int            bad   = 0;
    logic [NB-1:0] ref_fb;
    bit            tx[$];

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic chk_fb(input string name, input logic [NB-1:0] act, input logic [NB-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic push(input int kind, input int nbits, input bit ovf, input int cmd);
        exp_t e;
        e.kind  = kind;
        e.fb    = ref_fb;
        e.nbits = nbits;
        e.ovf   = ovf;
        e.cmd   = cmd;
        expq.push_back(e);
    endtask

    task automatic add_bits(input int val, input int w);
        for (int i = w - 1; i >= 0; i--) tx.push_back(bit'((val >> i) & 1));
    endtask

    // Reference: decode the whole frame from its bit list by the link's rules.
    task automatic model_frame();
        int nb, id, addr, cmd, nd, idx;
        bit ovf;
        nb = tx.size();
        if (nb < 3) begin
            push(K_SHORT, 0, 0, 0);
            return;
        end
        id = tx[0] * 4 + tx[1] * 2 + tx[2];
        if (id == 5) begin
            if (nb < 10) begin
                push(K_SHORT, 0, 0, 0);
            end else begin
                addr = 0;
                for (int i = 3; i < 10; i++) addr = addr * 2 + tx[i];
                nd  = nb - 10;
                ovf = 0;
                for (int i = 0; i < nd; i++) begin
                    idx = addr * 4 + i;
                    if (idx < NB) ref_fb[idx] = tx[10 + i];
                    else ovf = 1;
                end
                push(K_DONE, (nd < NB) ? nd : NB, ovf, 0);
            end
        end else if (id == 4) begin
`ifdef LED_RX_CMD_DECODE_EN
            if (nb < 12) begin
                push(K_SHORT, 0, 0, 0);
            end else begin
                cmd = 0;
                for (int i = 3; i < 11; i++) cmd = cmd * 2 + tx[i];
                push(K_CMD, 0, 0, cmd);
            end
`endif
        end else begin
            push(K_ID, 0, 0, 0);
        end
    endtask

    task automatic send_frame(input bit same_edge, input bit leave_open);
        link.cs = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_frame", busy, 1);
        for (int i = 0; i < tx.size(); i++) begin
            link.data  = tx[i];
            link.write = 1'b0;
            repeat (2) @(negedge clk);
            link.write = 1'b1;
            if (same_edge && !leave_open && i == tx.size() - 1) link.cs = 1'b1;
            repeat (2) @(negedge clk);
        end
        link.write = 1'b0;
        if (!leave_open) begin
            repeat (2) @(negedge clk);
            link.cs = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic run_frame(input bit same_edge);
        model_frame();
        send_frame(same_edge, 1'b0);
    endtask

    // Monitor: every output event pops the oldest expectation.
    int   obs_kind;
    exp_t cur;
    always @(negedge clk) begin
        if (rst === 1'b0 && (frame_done || err_id || err_short || cmd_valid)) begin
            if (frame_done)      obs_kind = K_DONE;
            else if (err_id)     obs_kind = K_ID;
            else if (err_short)  obs_kind = K_SHORT;
            else                 obs_kind = K_CMD;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event got kind=%0d want none", obs_kind);
            end else begin
                cur = expq.pop_front();
                chk("event_kind", obs_kind, cur.kind);
                if (cur.kind == K_DONE && obs_kind == K_DONE) begin
                    chk_fb("fb_image", fb, cur.fb);
                    chk("frame_nbits", int'(frame_nbits), cur.nbits);
                    chk("err_ovf", int'(err_ovf), int'(cur.ovf));
                end
                if (cur.kind == K_CMD && obs_kind == K_CMD)
                    chk("last_cmd", int'(last_cmd), cur.cmd);
            end
        end
    end

    int r, nd, k, id;

    initial begin
        rst        = 1'b1;
        link.cs    = 1'b1;
        link.write = 1'b0;
        link.data  = 1'b0;
        ref_fb     = '0;
        repeat (4) @(negedge clk);
        chk_fb("rst_fb", fb, '0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nbits", int'(frame_nbits), 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_last_cmd", int'(last_cmd), 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // full frame, only bit 0 set
        tx.delete(); add_bits(5, 3); add_bits(0, 7); tx.push_back(1'b1);
        repeat (NB - 1) tx.push_back(1'b0);
        run_frame(1'b0);

        // address 2, 8 ones
        tx.delete(); add_bits(5, 3); add_bits(2, 7); add_bits(8'hFF, 8);
        run_frame(1'b0);

        // unsupported ID with trailing strobes
        tx.delete(); add_bits(6, 3);
        repeat (20) tx.push_back(bit'($urandom_range(0, 1)));
        run_frame(1'b0);
        chk_fb("fb_after_bad_id", fb, ref_fb);

        // overflow: 400 data bits from address 0
        tx.delete(); add_bits(5, 3); add_bits(0, 7);
        repeat (400) tx.push_back(bit'($urandom_range(0, 1)));
        run_frame(1'b0);
        chk("err_ovf_sticky", err_ovf, 1);

        // address only, no data bits
        tx.delete(); add_bits(5, 3); add_bits(5, 7);
        run_frame(1'b0);

        // last strobe coincides with cs release
        tx.delete(); add_bits(5, 3); add_bits(10, 7); add_bits(6'b101101, 6);
        run_frame(1'b1);

        // cs released inside the address field
        tx.delete(); add_bits(5, 3); add_bits(1, 2);
        run_frame(1'b0);

        // command frame 0x03 + trailing bit
        tx.delete(); add_bits(4, 3); add_bits(8'h03, 8); tx.push_back(1'b1);
        run_frame(1'b0);
`ifdef LED_RX_CMD_DECODE_EN
        chk("last_cmd_hold", int'(last_cmd), 3);
`else
        chk("last_cmd_tied", int'(last_cmd), 0);
`endif

        // truncated command frame
        tx.delete(); add_bits(4, 3); add_bits(2, 5);
        run_frame(1'b0);

        for (int f = 0; f < 30; f++) begin
            tx.delete();
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: begin
                    add_bits(5, 3); add_bits($urandom_range(0, 100), 7);
                    nd = $urandom_range(0, 40);
                    repeat (nd) tx.push_back(bit'($urandom_range(0, 1)));
                end
                6: begin
                    id = $urandom_range(0, 7);
                    if (id == 4 || id == 5) id = 7;
                    add_bits(id, 3);
                    nd = $urandom_range(0, 10);
                    repeat (nd) tx.push_back(bit'($urandom_range(0, 1)));
                end
                7: begin
                    add_bits(4, 3); add_bits($urandom_range(0, 511), 9);
                    nd = $urandom_range(0, 5);
                    repeat (nd) tx.push_back(bit'($urandom_range(0, 1)));
                end
                8: begin
                    add_bits(5, 3); add_bits($urandom_range(0, 127), 7);
                    k = $urandom_range(0, 9);
                    while (tx.size() > k) void'(tx.pop_back());
                end
                default: begin
                    add_bits(4, 3); add_bits($urandom_range(0, 255), 8);
                    k = $urandom_range(0, 11);
                    while (tx.size() > k) void'(tx.pop_back());
                end
            endcase
            run_frame(bit'($urandom_range(0, 1)));
        end

        // reset in the middle of a data field: no event, image cleared
        tx.delete(); add_bits(5, 3); add_bits(0, 7);
        repeat (20) tx.push_back(bit'($urandom_range(0, 1)));
        send_frame(1'b0, 1'b1);
        rst     = 1'b1;
        link.cs = 1'b1;
        repeat (3) @(negedge clk);
        chk_fb("rst_mid_fb", fb, '0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        ref_fb = '0;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk_fb("post_rst_fb", fb, '0);

        tx.delete(); add_bits(5, 3); add_bits(1, 7); add_bits(8'hA5, 8);
        run_frame(1'b0);

        repeat (20) @(negedge clk);
        chk("pending_events", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
